writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the memory stage.
- Latches the memory stage's outputs into a MEM/WB register and selects the result word (ALU, memory, FPU, link or LHI immediate).
- Drives the register-file write port and a same-cycle forwarding bus.
- Halt FSM stops architectural writes on a trap; optional retirement and cycle counters.

Parameters:
- OP_LHI, 6'h0F, opcode of load-high-immediate
- OP_TRAP, 6'h11, opcode that halts the machine
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- stall  in  1  hold MEM/WB register contents
- NextMEMDout  in  32  load data from the memory stage
- NextALUOut  in  32  ALU result
- NextFPUOut  in  32  FPU result
- NextPCPlusFour  in  32  link value
- NextImmediate  in  16  instruction immediate
- NextOpcode  in  6  opcode
- NextFunct  in  6  funct field
- NextDInSrc  in  2  result select
- NextRegWE  in  1  register write request
- NextRegWAddr  in  6  destination; 0-31 integer, 32-63 FP
- RegWData  out  32  register-file write data
- RegWAddr  out  6  register-file write address
- RegWE  out  1  register-file write enable
- FwdValid  out  1  equals RegWE; qualifies forwarding
- Halted  out  1  machine halted
- RetiredCount  out  CNT_W  retired instructions (optional)
- CycleCount  out  CNT_W  cycles since reset (optional)

Behaviour:
- MEM/WB register
  - Async reset clears every field to 0.
  - On posedge clk with stall=0: load all Next* inputs. With stall=1: hold.
  - While state=HALTED the register keeps loading, but nothing is written (see write enable).
- Result mux (combinational from the register), on DInSrc:
  - 00: ALU. If opcode==OP_LHI, use {immediate,16'h0000} instead.
  - 01: MEMDout.
  - 10: FPUOut.
  - 11: PCPlusFour.
- Write address: RegWAddr = latched reg_w_addr.
- Write enable: RegWE = reg_we & (state==RUN) & (reg_w_addr != 6'd0) & !(opcode==OP_TRAP).
  - Integer r0 is never written. FP register 32 (f0) is writable.
- Latency: an instruction presented on Next* at edge N drives RegWE/RegWData for the cycle after edge N.
  - Register file writes at edge N+1.
- Stall: the held instruction keeps RegWE asserted. The repeated write is idempotent and is allowed.
- Bubble: opcode==0 & funct==0 & reg_we==0.
  - Bubbles are not counted as retired and have no other side effect.
- Halt FSM, states RUN and HALTED; reset -> RUN.
  - RUN -> HALTED: on the edge where stall=0 and the latched opcode==OP_TRAP.
  - HALTED is absorbing until reset.
  - Halted = (state==HALTED) | (latched opcode==OP_TRAP). Halted therefore asserts in the same cycle the trap reaches WB.
  - The trap itself writes nothing. Instructions before it have already written.
  - Reset mid-operation: state returns to RUN and Halted deasserts asynchronously.
- Reset values of all outputs: RegWData 0, RegWAddr 0, RegWE 0, FwdValid 0, Halted 0, counters 0.

Optional Feature:
- Macro WB_PERF_COUNT_EN. When defined:
  - CycleCount increments every cycle while state==RUN.
  - RetiredCount increments on each edge with stall=0, state==RUN and a latched non-bubble instruction. The trap counts.
  - Both counters freeze once HALTED and wrap modulo 2^CNT_W.
- Macro undefined: no counter flops; RetiredCount and CycleCount tie to 0.

Decomposition:
- Shared package holds:
  - opcode constants OP_LHI and OP_TRAP
  - DInSrc encodings SRC_ALU=2'b00, SRC_MEM=2'b01, SRC_FPU=2'b10, SRC_LINK=2'b11
  - FSM state encoding.
- One natural sub-module, wb_result_mux: purely combinational DInSrc/LHI selection, reusable by the forwarding unit.

Test Plan:
- Reset mid-run, then ALU path: reset high mid-stream clears all outputs to 0. Then NextDInSrc=00, ALUOut=32'h1234_5678, RegWE=1, RegWAddr=5 -> next cycle RegWData=32'h1234_5678, RegWAddr=5, RegWE=1.
- LHI and link:
  - opcode=6'h0F, Immediate=16'hBEEF, DInSrc=00 -> RegWData=32'hBEEF_0000.
  - DInSrc=11, PCPlusFour=32'h40 -> RegWData=32'h40.
- r0 suppression and FP write: RegWAddr=0, RegWE=1 -> RegWE=0. RegWAddr=32, FPUOut=32'h3F80_0000 -> RegWE=1.
- Stall hold: load with MEMDout=32'hCAFE then assert stall 3 cycles while Next* changes -> outputs stay 32'hCAFE/same address. RetiredCount increments by 1 only.
- Trap:
  - Trap followed by an add to r3 -> Halted=1 in the trap's WB cycle.
  - The add never asserts RegWE.
  - CycleCount and RetiredCount freeze.
  - Reset returns Halted to 0.
- Counters: 10 instructions with 3 bubbles interleaved -> RetiredCount=10. With WB_PERF_COUNT_EN undefined -> counters read 0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage and its result mux.
//   - Opcode constants (LHI, TRAP), DInSrc encodings, halt FSM state type.
//   - mem_wb_t: the MEM/WB pipeline register contents.
//   - is_bubble(): identifies pipeline bubbles (no retirement side effect).
package writeback_stage_pkg;

  localparam logic [5:0] OP_LHI  = 6'h0F;
  localparam logic [5:0] OP_TRAP = 6'h11;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_FPU  = 2'b10;
  localparam logic [1:0] SRC_LINK = 2'b11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic [31:0] mem_dout;
    logic [31:0] alu_out;
    logic [31:0] fpu_out;
    logic [31:0] pc_plus_four;
    logic [15:0] imm;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  din_src;
    logic        reg_we;
    logic [5:0]  reg_w_addr;
  } mem_wb_t;

  function automatic logic is_bubble(input logic [5:0] opcode,
                                     input logic [5:0] funct,
                                     input logic       reg_we);
    return (opcode == 6'd0) && (funct == 6'd0) && !reg_we;
  endfunction

endpackage

// File: rtl/writeback_stage_result_mux.sv
// wb_result_mux: combinational result-word selection for writeback.
//   din_src  : selects ALU / memory / FPU / link value
//   opcode   : LHI overrides the ALU path with {imm, 16'h0}
//   imm, alu_out, mem_dout, fpu_out, pc_plus_four : candidate sources
//   result   : selected write data
// Kept separate so the forwarding unit can reuse the same selection.
module wb_result_mux
  import writeback_stage_pkg::*;
(
  input  logic [1:0]  din_src,
  input  logic [5:0]  opcode,
  input  logic [15:0] imm,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_dout,
  input  logic [31:0] fpu_out,
  input  logic [31:0] pc_plus_four,
  output logic [31:0] result
);

  always_comb begin
    result = alu_out;
    case (din_src)
      SRC_ALU:  result = (opcode == OP_LHI) ? {imm, 16'h0000} : alu_out;
      SRC_MEM:  result = mem_dout;
      SRC_FPU:  result = fpu_out;
      SRC_LINK: result = pc_plus_four;
      default:  result = alu_out;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage.
//   clk, reset (async, active-high), stall (hold MEM/WB register)
//   Next*        : memory-stage outputs latched into MEM/WB
//   RegWData/RegWAddr/RegWE : register-file write port
//   FwdValid     : same-cycle forwarding qualifier (== RegWE)
//   Halted       : trap reached WB or machine already halted
//   RetiredCount/CycleCount : performance counters, present only when
//                  WB_PERF_COUNT_EN is defined, otherwise tied to 0.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      NextMEMDout,
  input  logic [31:0]      NextALUOut,
  input  logic [31:0]      NextFPUOut,
  input  logic [31:0]      NextPCPlusFour,
  input  logic [15:0]      NextImmediate,
  input  logic [5:0]       NextOpcode,
  input  logic [5:0]       NextFunct,
  input  logic [1:0]       NextDInSrc,
  input  logic             NextRegWE,
  input  logic [5:0]       NextRegWAddr,
  output logic [31:0]      RegWData,
  output logic [5:0]       RegWAddr,
  output logic             RegWE,
  output logic             FwdValid,
  output logic             Halted,
  output logic [CNT_W-1:0] RetiredCount,
  output logic [CNT_W-1:0] CycleCount
);

  mem_wb_t   mw, mw_nxt;
  wb_state_e state, state_nxt;

  always_comb begin
    mw_nxt              = '0;
    mw_nxt.mem_dout     = NextMEMDout;
    mw_nxt.alu_out      = NextALUOut;
    mw_nxt.fpu_out      = NextFPUOut;
    mw_nxt.pc_plus_four = NextPCPlusFour;
    mw_nxt.imm          = NextImmediate;
    mw_nxt.opcode       = NextOpcode;
    mw_nxt.funct        = NextFunct;
    mw_nxt.din_src      = NextDInSrc;
    mw_nxt.reg_we       = NextRegWE;
    mw_nxt.reg_w_addr   = NextRegWAddr;
  end

  // Keeps loading while halted; writes are blocked by RegWE instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       mw <= '0;
    else if (!stall) mw <= mw_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && !stall && mw.opcode == OP_TRAP)
      state_nxt = ST_HALTED;
  end

  wb_result_mux u_mux (
    .din_src      (mw.din_src),
    .opcode       (mw.opcode),
    .imm          (mw.imm),
    .alu_out      (mw.alu_out),
    .mem_dout     (mw.mem_dout),
    .fpu_out      (mw.fpu_out),
    .pc_plus_four (mw.pc_plus_four),
    .result       (RegWData)
  );

  // Only integer r0 is hardwired; address 32 is f0 and is writable.
  assign RegWAddr = mw.reg_w_addr;
  assign RegWE    = mw.reg_we && (state == ST_RUN) && (mw.reg_w_addr != 6'd0)
                    && (mw.opcode != OP_TRAP);
  assign FwdValid = RegWE;
  // Combinational term lets Halted rise in the trap's own WB cycle.
  assign Halted   = (state == ST_HALTED) || (mw.opcode == OP_TRAP);

`ifdef WB_PERF_COUNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (state == ST_RUN) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (!stall && !is_bubble(mw.opcode, mw.funct, mw.reg_we))
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign CycleCount   = cyc_q;
  assign RetiredCount = ret_q;
`else
  logic unused_funct;
  assign unused_funct = ^mw.funct;
  assign CycleCount   = '0;
  assign RetiredCount = '0;
`endif

endmodule
